spi_arbiter: RTL and testbench

Round-robin arbiter that shares one 12-bit SPI master among several requesters. It accepts word requests, issues exactly one `newd` pulse per granted word with `din` held stable, and tracks completion by watching the master's chip-select. A timeout guards against a stuck bus. It sits between client logic and `spi_master`, and is the only driver of the master's `newd`/`din`.

---
 rtl/spi_arbiter.sv | 108 ++++++++++
 tb/tb_spi_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master, cs-tracked completion with timeout
module spi_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 12,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              spi_newd,
  output logic [DW-1:0]     spi_din,
  input  logic              spi_cs
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_END, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, own, own_n, gidx;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [NREQ-1:0] ack_n, done_n;
  logic [DW-1:0] din_n;
  logic found, err_n, newd_n, tmo;
  always_comb begin
    found = 1'b0;
    gidx = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[PW'((int'(ptr) + i) % NREQ)]) begin
        found = 1'b1;
        gidx = PW'((int'(ptr) + i) % NREQ);
      end
  end
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    tcnt_n = tcnt;
    gcnt_n = gcnt;
    ack_n = '0;
    done_n = '0;
    err_n = 1'b0;
    newd_n = 1'b0;
    din_n = spi_din;
    case (state)
      IDLE: if (found) begin
        state_n = WAIT_START;
        ack_n = NREQ'(1) << gidx;
        newd_n = 1'b1;
        din_n = req_data[gidx*DW +: DW];
        own_n = gidx;
        ptr_n = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        tcnt_n = '0;
      end
      WAIT_START: if (tmo) begin
        err_n = 1'b1;
        state_n = GAP;
        gcnt_n = '0;
      end else begin
        tcnt_n = tcnt + 1'b1;
        state_n = spi_cs ? WAIT_START : WAIT_END;
      end
      WAIT_END: if (spi_cs || tmo) begin
        done_n = spi_cs ? NREQ'(1) << own : '0;
        err_n = !spi_cs;
        state_n = GAP;
        gcnt_n = '0;
      end else
        tcnt_n = tcnt + 1'b1;
      GAP: if (gcnt == GW'(GAP_CYC - 1)) state_n = IDLE;
        else gcnt_n = gcnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      tcnt <= '0;
      gcnt <= '0;
      ack <= '0;
      done <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      spi_newd <= 1'b0;
      spi_din <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      tcnt <= tcnt_n;
      gcnt <= gcnt_n;
      ack <= ack_n;
      done <= done_n;
      err <= err_n;
      busy <= state_n != IDLE;
      spi_newd <= newd_n;
      spi_din <= din_n;
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scenario tasks checked against a pending-mask/pointer reference model
module tb_spi_arbiter;
  localparam int NREQ = 4, DW = 12, GAP_CYC = 2, TIMEOUT = 4096;
  logic clk = 0, rst = 1, spi_cs = 1;
  logic [NREQ-1:0] req = '0, ack, done, pend = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic err, busy, spi_newd;
  logic [DW-1:0] spi_din;
  logic [DW-1:0] wd [NREQ];
  int ncmp = 0, nerr = 0, mptr = 0;
  always #5 clk = ~clk;
  spi_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .err(err), .busy(busy), .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs));
  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction
  task automatic drive();
    req = pend;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = wd[i];
  endtask
  task automatic do_reset();
    rst = 1; spi_cs = 1; pend = '0; mptr = 0; drive();
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask
  task automatic wait_quiet(input int n, input logic [DW-1:0] w);
    repeat (n) begin
      @(negedge clk);
      ncmp++;
      if (ack !== '0 || done !== '0 || err !== 0 || spi_newd !== 0 || busy !== 1 || spi_din !== w) begin
        nerr++;
        $display("FAIL wait_quiet: ack=%b done=%b err=%b newd=%b busy=%b din=%h, want zeros busy=1 din=%h", ack, done, err, spi_newd, busy, spi_din, w);
      end
    end
  endtask
  task automatic xfer(input int d, input int l, input bit spur, input bit hold, input logic [NREQ-1:0] glitch);
    int g;
    logic [DW-1:0] w;
    logic [NREQ-1:0] oh;
    g = pick();
    ncmp++;
    if (g < 0) begin
      nerr++;
      $display("FAIL xfer_setup: no pending request, want one");
      return;
    end
    oh = '0; oh[g] = 1'b1; w = wd[g];
    @(negedge clk);
    ncmp++;
    if (ack !== oh || spi_newd !== 1 || spi_din !== w || busy !== 1 || done !== '0 || err !== 0) begin
      nerr++;
      $display("FAIL grant: ack=%b newd=%b din=%h busy=%b done=%b err=%b, want ack=%b newd=1 din=%h busy=1", ack, spi_newd, spi_din, busy, done, err, oh, w);
    end
    mptr = (g + 1) % NREQ;
    if (!hold) pend[g] = 1'b0;
    drive();
    if (l < 0) begin
      wait_quiet(TIMEOUT - 1, w);
      @(negedge clk);
      ncmp++;
      if (err !== 1 || done !== '0 || ack !== '0) begin
        nerr++;
        $display("FAIL timeout_err: err=%b done=%b ack=%b, want err=1 done=0 ack=0", err, done, ack);
      end
    end else begin
      wait_quiet(d, w);
      spi_cs = 0; req = pend | glitch;
      wait_quiet(l, w);
      spi_cs = 1; req = pend;
      @(negedge clk);
      ncmp++;
      if (done !== oh || err !== 0 || ack !== '0 || busy !== 1) begin
        nerr++;
        $display("FAIL done: done=%b err=%b ack=%b busy=%b, want done=%b err=0 ack=0 busy=1", done, err, ack, busy, oh);
      end
    end
    spi_cs = !spur;
    repeat (GAP_CYC - 1) begin
      @(negedge clk);
      ncmp++;
      if (busy !== 1 || done !== '0 || err !== 0 || ack !== '0) begin
        nerr++;
        $display("FAIL gap: busy=%b done=%b err=%b ack=%b, want busy=1 and no pulses", busy, done, err, ack);
      end
      spi_cs = 1;
    end
    @(negedge clk);
    spi_cs = 1;
    ncmp++;
    if (busy !== 0 || done !== '0 || err !== 0 || ack !== '0 || spi_newd !== 0 || spi_din !== w) begin
      nerr++;
      $display("FAIL back_idle: busy=%b done=%b err=%b ack=%b newd=%b din=%h, want all 0 din=%h", busy, done, err, ack, spi_newd, spi_din, w);
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    ncmp++;
    if (ack !== '0 || done !== '0 || err !== 0 || busy !== 0 || spi_newd !== 0 || spi_din !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: ack=%b done=%b err=%b busy=%b newd=%b din=%h, want all 0", ack, done, err, busy, spi_newd, spi_din);
    end
    do_reset();
    repeat (3) begin
      @(negedge clk);
      ncmp++;
      if (busy !== 0 || ack !== '0 || spi_newd !== 0) begin
        nerr++;
        $display("FAIL idle_no_req: busy=%b ack=%b newd=%b, want 0", busy, ack, spi_newd);
      end
    end
  endtask
  task automatic test_single();
    pend = 4'b0001; wd[0] = 12'hA5C; drive();
    xfer(1, 13, 0, 0, '0);
  endtask
  task automatic test_pair();
    do_reset();
    pend = 4'b1010; wd[1] = 12'h123; wd[3] = 12'h3C7; drive();
    xfer(1, 4, 0, 0, '0);
    xfer(2, 6, 0, 0, '0);
    ncmp++;
    if (mptr !== 0) begin
      nerr++;
      $display("FAIL pair_ptr: model ptr=%0d, want 0", mptr);
    end
  endtask
  task automatic test_all4();
    do_reset();
    pend = '1;
    for (int i = 0; i < NREQ; i++) wd[i] = DW'($urandom);
    drive();
    for (int n = 0; n < 8; n++) xfer($urandom_range(0, 3), $urandom_range(1, 12), 0, 1, '0);
    pend = '0; drive();
  endtask
  task automatic test_timeout();
    pend = 4'b0100; wd[2] = 12'hE01; drive();
    xfer(0, -1, 0, 0, '0);
    pend = 4'b0001; wd[0] = 12'h0F0; drive();
    xfer(1, 3, 0, 0, '0);
  endtask
  task automatic test_rst_mid();
    do_reset();
    pend = 4'b0100; wd[2] = 12'h5A5; drive();
    @(negedge clk);
    ncmp++;
    if (ack !== 4'b0100 || spi_newd !== 1 || spi_din !== 12'h5A5) begin
      nerr++;
      $display("FAIL rst_pre_grant: ack=%b newd=%b din=%h, want 0100 1 5a5", ack, spi_newd, spi_din);
    end
    pend = 4'b1100; wd[2] = 12'h2B2; wd[3] = 12'h3B3; drive();
    spi_cs = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    ncmp++;
    if (ack !== '0 || done !== '0 || err !== 0 || busy !== 0 || spi_newd !== 0 || spi_din !== '0) begin
      nerr++;
      $display("FAIL async_reset: ack=%b done=%b err=%b busy=%b newd=%b din=%h, want all 0", ack, done, err, busy, spi_newd, spi_din);
    end
    spi_cs = 1; mptr = 0;
    @(negedge clk);
    rst = 0;
    xfer(0, 5, 0, 0, '0);
    xfer(2, 2, 0, 0, '0);
  endtask
  task automatic test_glitch_spur();
    pend = 4'b0010; wd[1] = 12'h7E7; drive();
    xfer(1, 5, 1, 0, 4'b0001);
    pend = 4'b1000; wd[3] = 12'h0C3; drive();
    xfer(0, 3, 1, 0, 4'b0001);
    repeat (4) begin
      @(negedge clk);
      ncmp++;
      if (ack !== '0 || busy !== 0 || done !== '0 || err !== 0) begin
        nerr++;
        $display("FAIL glitch_not_served: ack=%b busy=%b done=%b err=%b, want 0", ack, busy, done, err);
      end
    end
  endtask
  task automatic test_random();
    logic [NREQ-1:0] add;
    for (int n = 0; n < 40; n++) begin
      add = NREQ'($urandom);
      if ((pend | add) == '0) add[$urandom_range(0, NREQ-1)] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (add[i] && !pend[i]) wd[i] = DW'($urandom);
      pend = pend | add;
      drive();
      xfer($urandom_range(0, 3), $urandom_range(1, 16), 1'($urandom), 0, ~pend & NREQ'($urandom));
    end
  endtask
  initial begin
    for (int i = 0; i < NREQ; i++) wd[i] = '0;
    test_reset();
    test_single();
    test_pair();
    test_all4();
    test_timeout();
    test_rst_mid();
    test_glitch_spur();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
